sifh_peak_reader: RTL and testbench

//  Read side of the SiFH histogram RAM. After acquisition, sweeps every pixel's bins through the read port.

---
 rtl/sifh_peak_reader_if.sv | 43 ++++
 rtl/sifh_peak_reader.sv | 142 ++++++++++++++
 tb/tb_sifh_peak_reader.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sifh_peak_reader_if.sv
// Histogram RAM read port, control handshake and peak-result stream of the SiFH peak reader.
// The clear write port (waddr/wEnable/wdata) exists only when SIFH_CLEAR_ON_READ_EN is defined.
interface sifh_peak_reader_if #(
    parameter int NB       = 10,
    parameter int NP       = 6,
    parameter int PEAK_MAX = 8,
    parameter int PIX_W    = 4
);
    logic                start;
    logic                busy;
    logic                done;
    logic [NB-1:0]       raddr;
    logic                rEnable;
    logic [PEAK_MAX-1:0] rdata;
    logic                peak_valid;
    logic                peak_ready;
    logic [PIX_W-1:0]    peak_pixel;
    logic [NP-1:0]       peak_bin;
    logic [PEAK_MAX-1:0] peak_count;
`ifdef SIFH_CLEAR_ON_READ_EN
    logic [NB-1:0]       waddr;
    logic                wEnable;
    logic [PEAK_MAX-1:0] wdata;
`endif

    modport master (
        input  start, rdata, peak_ready,
`ifdef SIFH_CLEAR_ON_READ_EN
        output waddr, wEnable, wdata,
`endif
        output busy, done, raddr, rEnable,
        output peak_valid, peak_pixel, peak_bin, peak_count
    );

    modport slave (
        output start, rdata, peak_ready,
`ifdef SIFH_CLEAR_ON_READ_EN
        input  waddr, wEnable, wdata,
`endif
        input  busy, done, raddr, rEnable,
        input  peak_valid, peak_pixel, peak_bin, peak_count
    );
endinterface

// File: rtl/sifh_peak_reader.sv
// Sweeps every pixel histogram in the SiFH RAM, finds each pixel's peak bin and streams one result per pixel.
// Define SIFH_CLEAR_ON_READ_EN to zero every word through the write port as soon as it has been read.
module sifh_peak_reader #(
    parameter int NB       = 10,
    parameter int NP       = 6,
    parameter int PEAK_MAX = 8,
    parameter int BIN_NUM  = 64,
    parameter int PIX_NUM  = 16,
    parameter int PIX_W    = 4
) (
    input  logic               clk,
    input  logic               res,
    sifh_peak_reader_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [NP-1:0]    LP_BIN_LAST = NP'(BIN_NUM - 1);
    localparam logic [PIX_W-1:0] LP_PIX_LAST = PIX_W'(PIX_NUM - 1);
    localparam logic [NB-1:0]    LP_BIN_NUM  = NB'(BIN_NUM);

    state_t              r_state;
    state_t              w_next;

    logic [PIX_W-1:0]    r_pixel;
    logic [NP-1:0]       r_bin;
    logic [PEAK_MAX-1:0] r_max_cnt;
    logic [NP-1:0]       r_max_bin;
    logic                r_vld_p1;
    logic [NP-1:0]       r_bin_p1;
    logic [NB-1:0]       r_addr_p1;
    logic [PIX_W-1:0]    r_peak_pixel;
    logic [NP-1:0]       r_peak_bin;
    logic [PEAK_MAX-1:0] r_peak_count;

    logic [NB-1:0]       w_raddr;
    logic                w_start_ok;
    logic                w_take;
    logic                w_new_peak;
    logic [PEAK_MAX-1:0] w_cnt_next;
    logic [NP-1:0]       w_bin_next;

    // Strictly greater only, so the first (lowest) bin of a tie is kept.
    function automatic logic is_new_peak(input logic                vld,
                                         input logic [PEAK_MAX-1:0] sample,
                                         input logic [PEAK_MAX-1:0] best);
        return vld && (sample > best);
    endfunction

    assign w_raddr    = NB'(r_pixel) * LP_BIN_NUM + NB'(r_bin);
    assign w_start_ok = (r_state == S_IDLE) && bus.start;
    assign w_take     = (r_state == S_OUT) && bus.peak_ready;
    assign w_new_peak = is_new_peak(r_vld_p1, bus.rdata, r_max_cnt);
    assign w_cnt_next = w_new_peak ? bus.rdata : r_max_cnt;
    assign w_bin_next = w_new_peak ? r_bin_p1  : r_max_bin;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_READ;
            S_READ:  if (r_bin == LP_BIN_LAST) w_next = S_DRAIN;
            S_DRAIN: w_next = S_OUT;
            S_OUT:   if (bus.peak_ready) w_next = (r_pixel == LP_PIX_LAST) ? S_DONE : S_READ;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (r_state != S_IDLE);
        bus.done       = (r_state == S_DONE);
        bus.rEnable    = (r_state == S_READ);
        bus.raddr      = (r_state == S_READ) ? w_raddr : '0;
        bus.peak_valid = (r_state == S_OUT);
        bus.peak_pixel = r_peak_pixel;
        bus.peak_bin   = r_peak_bin;
        bus.peak_count = r_peak_count;
`ifdef SIFH_CLEAR_ON_READ_EN
        bus.wEnable    = r_vld_p1;
        bus.waddr      = r_vld_p1 ? r_addr_p1 : '0;
        bus.wdata      = '0;
`endif
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_pixel      <= '0;
            r_bin        <= '0;
            r_max_cnt    <= '0;
            r_max_bin    <= '0;
            r_vld_p1     <= 1'b0;
            r_bin_p1     <= '0;
            r_addr_p1    <= '0;
            r_peak_pixel <= '0;
            r_peak_bin   <= '0;
            r_peak_count <= '0;
        end else begin
            // p0 -> p1: the word read this cycle returns next cycle, tagged with its bin and address
            r_vld_p1  <= (r_state == S_READ);
            r_bin_p1  <= r_bin;
            r_addr_p1 <= w_raddr;

            if (w_start_ok) begin
                r_pixel <= '0;
                r_bin   <= '0;
            end else if (w_take) begin
                r_bin <= '0;
                if (r_pixel != LP_PIX_LAST) r_pixel <= r_pixel + 1'b1;
            end else if ((r_state == S_READ) && (r_bin != LP_BIN_LAST)) begin
                r_bin <= r_bin + 1'b1;
            end

            if (w_start_ok || w_take) begin
                r_max_cnt <= '0;
                r_max_bin <= '0;
            end else if (w_new_peak) begin
                r_max_cnt <= bus.rdata;
                r_max_bin <= r_bin_p1;
            end

            // p1 -> result: DRAIN folds in the last bin and freezes the result for the stream
            if (r_state == S_DRAIN) begin
                r_peak_pixel <= r_pixel;
                r_peak_bin   <= w_bin_next;
                r_peak_count <= w_cnt_next;
            end
        end
    end
endmodule

// File: tb/tb_sifh_peak_reader.sv
// Scoreboard bench for sifh_peak_reader: randomized histograms, reference peak search, stream monitor.
// Build with SIFH_CLEAR_ON_READ_EN defined to also cover the clear-on-read write port.
module tb_sifh_peak_reader;
    localparam int NB       = 10;
    localparam int NP       = 6;
    localparam int PEAK_MAX = 8;
    localparam int BIN_NUM  = 64;
    localparam int PIX_NUM  = 16;
    localparam int PIX_W    = 4;
    localparam int MEM_W    = BIN_NUM * PIX_NUM;
    localparam int BUDGET   = 6000;

    typedef struct {
        int pix;
        int bin;
        int cnt;
    } res_t;

    logic clk = 1'b0;
    logic res;
    logic load;
    int   ready_mode;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_res    = 0;

    logic [PEAK_MAX-1:0] mem [0:MEM_W-1];
    logic [PEAK_MAX-1:0] img [0:MEM_W-1];
    res_t                exp_q[$];
    res_t                mon_e;

    logic                prev_hold;
    logic [PIX_W-1:0]    prev_pix;
    logic [NP-1:0]       prev_bin;
    logic [PEAK_MAX-1:0] prev_cnt;

    always #5 clk = ~clk;

    sifh_peak_reader_if #(.NB(NB), .NP(NP), .PEAK_MAX(PEAK_MAX), .PIX_W(PIX_W)) bus ();

    sifh_peak_reader #(
        .NB(NB), .NP(NP), .PEAK_MAX(PEAK_MAX),
        .BIN_NUM(BIN_NUM), .PIX_NUM(PIX_NUM), .PIX_W(PIX_W)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %s", name, what);
    endtask

    // Histogram RAM: synchronous read, one-cycle latency; optional clear port.
    always @(posedge clk) begin
        if (load) begin
            mem <= img;
        end else begin
`ifdef SIFH_CLEAR_ON_READ_EN
            if (bus.wEnable) mem[bus.waddr] <= bus.wdata;
`endif
        end
        if (bus.rEnable) bus.rdata <= mem[bus.raddr];
    end

    // Ready driver: 0 = always ready, 1 = random, 2 = held low.
    always begin
        @(posedge clk);
        #2;
        case (ready_mode)
            1:       bus.peak_ready = ($urandom_range(0, 3) != 0);
            2:       bus.peak_ready = 1'b0;
            default: bus.peak_ready = 1'b1;
        endcase
    end

    // Monitor: pops the scoreboard on every handshake, checks hold stability and no reads in OUT.
    always @(negedge clk) begin
        if (res) begin
            prev_hold = 1'b0;
        end else begin
            if (bus.done) n_done++;
            if (prev_hold) begin
                check("hold_valid", int'(bus.peak_valid), 1);
                check("hold_pixel", int'(bus.peak_pixel), int'(prev_pix));
                check("hold_bin",   int'(bus.peak_bin),   int'(prev_bin));
                check("hold_count", int'(bus.peak_count), int'(prev_cnt));
            end
            if (bus.peak_valid) check("no_read_in_out", int'(bus.rEnable), 0);
            if (bus.peak_valid && bus.peak_ready) begin
                n_res++;
                if (exp_q.size() == 0) begin
                    fail_event("unexpected_result", "result with empty scoreboard, required none");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("peak_pixel", int'(bus.peak_pixel), mon_e.pix);
                    check("peak_bin",   int'(bus.peak_bin),   mon_e.bin);
                    check("peak_count", int'(bus.peak_count), mon_e.cnt);
                end
            end
            prev_hold = bus.peak_valid && !bus.peak_ready;
            prev_pix  = bus.peak_pixel;
            prev_bin  = bus.peak_bin;
            prev_cnt  = bus.peak_count;
        end
    end

    task automatic push_model();
        for (int p = 0; p < PIX_NUM; p++) begin
            int best_cnt;
            int best_bin;
            best_cnt = 0;
            best_bin = 0;
            for (int b = 0; b < BIN_NUM; b++) begin
                if (int'(img[p*BIN_NUM+b]) > best_cnt) begin
                    best_cnt = int'(img[p*BIN_NUM+b]);
                    best_bin = b;
                end
            end
            exp_q.push_back('{pix: p, bin: best_bin, cnt: best_cnt});
        end
    endtask

    task automatic fill_random();
        for (int p = 0; p < PIX_NUM; p++) begin
            int cap;
            cap = int'($urandom_range(0, 255));
            for (int b = 0; b < BIN_NUM; b++)
                img[p*BIN_NUM+b] = PEAK_MAX'($urandom_range(0, cap));
        end
    endtask

    task automatic fill_zero();
        for (int i = 0; i < MEM_W; i++) img[i] = '0;
    endtask

    task automatic load_img();
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    // Waits for done; optionally raises start in the done cycle, then checks the block went idle.
    task automatic wait_done(input string name, input bit start_on_done, input int done_before);
        int cyc;
        cyc = 0;
        while (!bus.done && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!bus.done) begin
            fail_event(name, "timeout waiting for done, required done pulse");
        end else begin
            if (start_on_done) bus.start = 1'b1;
            @(posedge clk); #1 bus.start = 1'b0;
            @(negedge clk);
            check({name, "_busy_after"}, int'(bus.busy), 0);
            check({name, "_rd_after"},   int'(bus.rEnable), 0);
            check({name, "_done_count"}, n_done - done_before, 1);
            check({name, "_left_in_q"},  exp_q.size(), 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int lat;
        int cyc;
        int d0;
        int r0;
        int bad;
        res        = 1'b1;
        load       = 1'b0;
        ready_mode = 0;
        bus.start  = 1'b0;
        prev_hold  = 1'b0;
        fill_zero();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",    int'(bus.busy), 0);
        check("rst_done",    int'(bus.done), 0);
        check("rst_ren",     int'(bus.rEnable), 0);
        check("rst_raddr",   int'(bus.raddr), 0);
        check("rst_valid",   int'(bus.peak_valid), 0);
        check("rst_pixel",   int'(bus.peak_pixel), 0);
        check("rst_bin",     int'(bus.peak_bin), 0);
        check("rst_count",   int'(bus.peak_count), 0);
`ifdef SIFH_CLEAR_ON_READ_EN
        check("rst_wen",     int'(bus.wEnable), 0);
        check("rst_waddr",   int'(bus.waddr), 0);
`endif
        @(posedge clk); #1 res = 1'b0;

        // Single peak in pixel 0, first-result latency with ready held high.
        fill_zero();
        img[5] = 8'd9;
        load_img();
        push_model();
        d0 = n_done;
        bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        lat = 1;
        check("t1_busy_after_start", int'(bus.busy), 1);
        while (!bus.peak_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("t1_latency", lat, BIN_NUM + 2);
        wait_done("t1", 1'b0, d0);
`ifndef SIFH_CLEAR_ON_READ_EN
        bad = 0;
        for (int i = 0; i < MEM_W; i++) if (mem[i] != img[i]) bad++;
        check("ram_untouched_words", bad, 0);
`endif

        // Random histograms with a forced tie in pixel 3, random ready, start pulsed mid-sweep.
        fill_random();
        for (int b = 0; b < BIN_NUM; b++)
            if (img[3*BIN_NUM+b] >= 8'd200) img[3*BIN_NUM+b] = 8'd199;
        img[3*BIN_NUM+7]  = 8'd200;
        img[3*BIN_NUM+20] = 8'd200;
        load_img();
        push_model();
        d0 = n_done;
        ready_mode = 1;
        pulse_start();
        repeat (300) @(posedge clk);
        #1;
        pulse_start();
        wait_done("t2", 1'b0, d0);

        // All-zero RAM: sixteen bin-0/count-0 results, start coincident with done ignored.
        fill_zero();
        load_img();
        push_model();
        d0 = n_done;
        r0 = n_res;
        ready_mode = 0;
        pulse_start();
        wait_done("t3", 1'b1, d0);
        check("t3_results", n_res - r0, PIX_NUM);

        // Ready held low ten cycles while pixel 2 is presented.
        fill_random();
        load_img();
        push_model();
        d0 = n_done;
        pulse_start();
        cyc = 0;
        while (!(bus.peak_valid && bus.peak_pixel == 4'd2) && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= BUDGET) fail_event("t4_wait_pix2", "timeout, required pixel 2 result");
        ready_mode = 2;
        repeat (10) @(posedge clk);
        #1 ready_mode = 0;
        wait_done("t4", 1'b0, d0);

        // Reset in the middle of reading pixel 4, then a clean sweep from pixel 0.
        fill_random();
        load_img();
        push_model();
        ready_mode = 1;
        pulse_start();
        cyc = 0;
        while (!(bus.rEnable && bus.raddr == NB'(4*BIN_NUM+10)) && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= BUDGET) fail_event("t5_wait_pix4", "timeout, required read of pixel 4");
        res = 1'b1;
        @(negedge clk);
        check("t5_busy",  int'(bus.busy), 0);
        check("t5_done",  int'(bus.done), 0);
        check("t5_ren",   int'(bus.rEnable), 0);
        check("t5_raddr", int'(bus.raddr), 0);
        check("t5_valid", int'(bus.peak_valid), 0);
        check("t5_pixel", int'(bus.peak_pixel), 0);
        check("t5_bin",   int'(bus.peak_bin), 0);
        check("t5_count", int'(bus.peak_count), 0);
        @(posedge clk); #1 res = 1'b0;
        exp_q.delete();
        load_img();
        push_model();
        d0 = n_done;
        pulse_start();
        wait_done("t5", 1'b0, d0);

`ifdef SIFH_CLEAR_ON_READ_EN
        // Clear-on-read: RAM is all zero after a sweep, and a second sweep sees only zeros.
        fill_random();
        img[100] = 8'd255;
        load_img();
        push_model();
        d0 = n_done;
        ready_mode = 1;
        pulse_start();
        wait_done("t6a", 1'b0, d0);
        bad = 0;
        for (int i = 0; i < MEM_W; i++) if (mem[i] != '0) bad++;
        check("t6_nonzero_words", bad, 0);
        for (int p = 0; p < PIX_NUM; p++) exp_q.push_back('{pix: p, bin: 0, cnt: 0});
        d0 = n_done;
        pulse_start();
        wait_done("t6b", 1'b0, d0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
